// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side C1/D1/A1 cache bus master:
// the C1 command/response codes, the master FSM state type and
// small command-decode helpers.
package cpu_bus_pkg;

  localparam logic [2:0] C1_NOP             = 3'd0;
  localparam logic [2:0] C1_READ8           = 3'd1;
  localparam logic [2:0] C1_READ16          = 3'd2;
  localparam logic [2:0] C1_READ32          = 3'd3;
  localparam logic [2:0] C1_INVALIDATE_LINE = 3'd4;
  localparam logic [2:0] C1_WRITE8          = 3'd5;
  localparam logic [2:0] C1_WRITE16         = 3'd6;
  localparam logic [2:0] C1_WRITE32         = 3'd7;
  // Shares its code with WRITE32; only the cache drives it, and only
  // while the master has released C1.
  localparam logic [2:0] C1_RESPONSE        = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD1,
    ST_CMD2,
    ST_WAIT,
    ST_RESP2,
    ST_TURN
  } state_t;

  function automatic logic is_write(input logic [2:0] cmd);
    return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
  endfunction

  function automatic logic is_read(input logic [2:0] cmd);
    return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
  endfunction

endpackage

// File: rtl/cpu_bus_master_if.sv
// Core-side request/response port of the cache bus master.
// modport master: the bus master itself; modport slave: the core.
interface cpu_bus_master_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_cmd;
  logic [ADDR_W-1:0]     req_addr;
  logic [2*DATA_W-1:0]   req_wdata;
  logic                  rsp_valid;
  logic [2*DATA_W-1:0]   rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    input  req_valid, req_cmd, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    output req_valid, req_cmd, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/cpu_bus_drv.sv
// Tristate pad driver for a shared bus: drives value while drive_en,
// otherwise releases the bus to high impedance.
module cpu_bus_drv #(
  parameter int W = 16
) (
  input  logic         drive_en,
  input  logic [W-1:0] value,
  inout  wire  [W-1:0] bus
);

  assign bus = drive_en ? value : {W{1'bz}};

endmodule

// File: rtl/cpu_bus_master.sv
// CPU-side master for the C1/D1/A1 cache bus. Takes one request at a
// time from the core, drives the command/address/write-data phases,
// releases the bus, waits for the cache RESPONSE, captures read data
// and returns a one-cycle completion in the TURN (turnaround) state.
//
// Build option: define CPU_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYC cycles without a response (completion with rsp_err=1).
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_bus_master_if.master    core,
  inout  wire  [DATA_W-1:0]   D1,
  inout  wire  [2:0]          C1,
  output logic [ADDR_W-1:0]   A1
);

  state_t                state;
  logic [2:0]            cmd_q;
  logic [2*DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]     rd_lo_q;

  logic                  c1_en;
  logic [2:0]            c1_val;
  logic                  d1_en;
  logic [DATA_W-1:0]     d1_val;
  logic [ADDR_W-1:0]     a1_q;

  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [2*DATA_W-1:0]   rsp_rdata_q;
  logic                  busy_q;
  logic [DATA_W-1:0]     rd_word;
  logic                  rsp_seen;

`ifdef CPU_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0]       wait_cnt;
  logic                  rsp_err_q;
`endif

  // An X/Z on C1 compares unknown and therefore never counts as a response.
  assign rsp_seen = (C1 == C1_RESPONSE);

  // Low data word as returned to the core: READ8 keeps only the low byte,
  // non-reads contribute nothing.
  always_comb begin
    rd_word = '0;
    if (cmd_q == C1_READ8)
      rd_word[7:0] = D1[7:0];
    else if (is_read(cmd_q))
      rd_word = D1;
  end

  // Protocol FSM; every bus and core-side output is a register so that
  // reset releases C1/D1 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_TURN;
      cmd_q       <= C1_NOP;
      wdata_q     <= '0;
      rd_lo_q     <= '0;
      c1_en       <= 1'b0;
      c1_val      <= C1_NOP;
      d1_en       <= 1'b0;
      d1_val      <= '0;
      a1_q        <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b1;
`ifdef CPU_TIMEOUT_EN
      wait_cnt    <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (core.req_valid && req_ready_q) begin
            cmd_q       <= core.req_cmd;
            wdata_q     <= core.req_wdata;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (core.req_cmd == C1_NOP) begin
              // No bus activity: straight to the completion cycle.
              state       <= ST_TURN;
              c1_en       <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
`ifdef CPU_TIMEOUT_EN
              rsp_err_q   <= 1'b0;
`endif
            end else begin
              state  <= ST_CMD1;
              c1_en  <= 1'b1;
              c1_val <= core.req_cmd;
              a1_q   <= core.req_addr;
              d1_en  <= is_write(core.req_cmd);
              d1_val <= core.req_wdata[DATA_W-1:0];
            end
          end
        end
        ST_CMD1: begin
          if (cmd_q == C1_WRITE32) begin
            // Second bus word keeps C1 and D1 driven for one more cycle.
            state  <= ST_CMD2;
            d1_val <= wdata_q[2*DATA_W-1:DATA_W];
          end else begin
            state <= ST_WAIT;
            c1_en <= 1'b0;
            d1_en <= 1'b0;
`ifdef CPU_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        ST_CMD2: begin
          state <= ST_WAIT;
          c1_en <= 1'b0;
          d1_en <= 1'b0;
`ifdef CPU_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (rsp_seen) begin
            if (cmd_q == C1_READ32) begin
              rd_lo_q <= D1;
              state   <= ST_RESP2;
            end else begin
              state       <= ST_TURN;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= {{DATA_W{1'b0}}, rd_word};
`ifdef CPU_TIMEOUT_EN
              rsp_err_q   <= 1'b0;
`endif
            end
          end
`ifdef CPU_TIMEOUT_EN
          // A response on the final counted edge is taken above and wins.
          else if (wait_cnt == TO_LAST) begin
            state       <= ST_TURN;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_RESP2: begin
          state       <= ST_TURN;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= {D1, rd_lo_q};
`ifdef CPU_TIMEOUT_EN
          rsp_err_q   <= 1'b0;
`endif
        end
        ST_TURN: begin
          // Bus turnaround done; park C1 on NOP and reopen the core port.
          state       <= ST_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          c1_en       <= 1'b1;
          c1_val      <= C1_NOP;
          d1_en       <= 1'b0;
        end
        default: begin
          state <= ST_TURN;
          c1_en <= 1'b0;
          d1_en <= 1'b0;
        end
      endcase
    end
  end

  assign core.req_ready = req_ready_q;
  assign core.rsp_valid = rsp_valid_q;
  assign core.rsp_rdata = rsp_rdata_q;
  assign core.busy      = busy_q;
`ifdef CPU_TIMEOUT_EN
  assign core.rsp_err   = rsp_err_q;
`else
  assign core.rsp_err   = 1'b0;
`endif
  assign A1             = a1_q;

  cpu_bus_drv #(.W(3)) u_c1_drv (
    .drive_en (c1_en),
    .value    (c1_val),
    .bus      (C1)
  );

  cpu_bus_drv #(.W(DATA_W)) u_d1_drv (
    .drive_en (d1_en),
    .value    (d1_val),
    .bus      (D1)
  );

endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: directed and random transactions, with a
// behavioural cache model on C1/D1 and a per-transaction expectation of
// the bus-cycle sequence and completion values.
module tb_cpu_bus_master;
  import cpu_bus_pkg::*;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int TB_TO  = 8;

  // Bus-cycle kinds the model expects after an accept.
  localparam int P_CMD1 = 0, P_CMD2 = 1, P_WAIT = 2, P_RESP2 = 3, P_TURN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire  [DATA_W-1:0] D1;
  wire  [2:0]        C1;
  logic [ADDR_W-1:0] A1;

  // Cache-side drivers.
  logic              tb_c1_en = 1'b0;
  logic [2:0]        tb_c1_val = 3'd0;
  logic              tb_d1_en = 1'b0;
  logic [DATA_W-1:0] tb_d1_val = '0;
  assign C1 = tb_c1_en ? tb_c1_val : 3'bzzz;
  assign D1 = tb_d1_en ? tb_d1_val : {DATA_W{1'bz}};

  cpu_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) core ();

  cpu_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TB_TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .core  (core),
    .D1    (D1),
    .C1    (C1),
    .A1    (A1)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [ADDR_W-1:0] last_a1 = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input logic [31:0] exp_rd);
    chk("idle_ready", core.req_ready, 1);
    chk("idle_busy", core.busy, 0);
    chk("idle_c1_en", dut.u_c1_drv.drive_en, 1);
    chk("idle_c1", C1, C1_NOP);
    chk("idle_d1_en", dut.u_d1_drv.drive_en, 0);
    chk("idle_rsp_valid", core.rsp_valid, 0);
    chk("idle_rdata_hold", core.rsp_rdata, exp_rd);
    chk("idle_a1_hold", A1, last_a1);
  endtask

  // One transaction. Entered and left at a negedge with the DUT in IDLE.
  // dly >= 0: cache answers in WAIT cycle number dly (0 = first);
  // dly < 0: no answer, only meaningful with the timeout build.
  task automatic run_txn(input logic [2:0] cmd, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wd, input int dly,
                         input logic [15:0] dlo, input logic [15:0] dhi, input bit hold);
    int ph[$];
    int nwait;
    int w;
    logic [31:0] exp_rd;
    logic exp_err;
    exp_err = 1'b0;
    case (cmd)
      C1_READ8:  exp_rd = {24'h0, dlo[7:0]};
      C1_READ16: exp_rd = {16'h0, dlo};
      C1_READ32: exp_rd = {dhi, dlo};
      default:   exp_rd = 32'h0;
    endcase
    nwait = dly + 1;
    if (dly < 0) begin
      nwait   = TB_TO;
      exp_rd  = 32'h0;
      exp_err = 1'b1;
    end
    if (cmd != C1_NOP) begin
      ph.push_back(P_CMD1);
      if (cmd == C1_WRITE32) ph.push_back(P_CMD2);
      repeat (nwait) ph.push_back(P_WAIT);
      if (cmd == C1_READ32 && dly >= 0) ph.push_back(P_RESP2);
    end
    ph.push_back(P_TURN);

    core.req_valid = 1'b1;
    core.req_cmd   = cmd;
    core.req_addr  = addr;
    core.req_wdata = wd;
    @(posedge clk);
    if (cmd != C1_NOP) last_a1 = addr;
    w = 0;
    foreach (ph[i]) begin
      @(negedge clk);
      if (!hold) begin
        core.req_valid = 1'b0;
        core.req_cmd   = 3'($urandom);
        core.req_addr  = ADDR_W'($urandom);
        core.req_wdata = $urandom;
      end
      chk("busy", core.busy, 1);
      chk("req_ready", core.req_ready, 0);
      chk("rsp_valid", core.rsp_valid, ph[i] == P_TURN);
      chk("c1_en", dut.u_c1_drv.drive_en, ph[i] == P_CMD1 || ph[i] == P_CMD2);
      chk("d1_en", dut.u_d1_drv.drive_en,
          (ph[i] == P_CMD1 && is_write(cmd)) || ph[i] == P_CMD2);
      chk("a1", A1, last_a1);
      if (ph[i] == P_CMD1 || ph[i] == P_CMD2) chk("c1_cmd", C1, cmd);
      if (ph[i] == P_CMD1 && is_write(cmd)) chk("d1_lo", D1, wd[15:0]);
      if (ph[i] == P_CMD2) chk("d1_hi", D1, wd[31:16]);
      if (ph[i] == P_TURN) begin
        chk("rsp_rdata", core.rsp_rdata, exp_rd);
        chk("rsp_err", core.rsp_err, exp_err);
      end
      tb_c1_en = 1'b0;
      tb_d1_en = 1'b0;
      if (ph[i] == P_WAIT) begin
        if (dly >= 0 && w == dly) begin
          tb_c1_en = 1'b1; tb_c1_val = C1_RESPONSE;
          tb_d1_en = 1'b1; tb_d1_val = dlo;
        end else begin
          // Non-response traffic on the bus must be ignored.
          tb_c1_en  = 1'($urandom);
          tb_c1_val = 3'($urandom_range(0, 6));
          tb_d1_en  = 1'($urandom);
          tb_d1_val = 16'($urandom);
        end
        w++;
      end else if (ph[i] == P_RESP2) begin
        tb_d1_en = 1'b1; tb_d1_val = dhi;
      end
    end
    @(negedge clk);
    chk_idle(exp_rd);
  endtask

  // Start a READ16, let it sit in WAIT for nwait cycles, then reset.
  task automatic rst_in_wait(input int nwait);
    core.req_valid = 1'b1;
    core.req_cmd   = C1_READ16;
    core.req_addr  = ADDR_W'($urandom);
    core.req_wdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    core.req_valid = 1'b0;
    for (int i = 0; i < nwait; i++) begin
      @(negedge clk);
      chk("wait_busy", core.busy, 1);
      chk("wait_no_rsp", core.rsp_valid, 0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_c1_z", dut.u_c1_drv.drive_en, 0);
    chk("rst_d1_z", dut.u_d1_drv.drive_en, 0);
    chk("rst_rsp_valid", core.rsp_valid, 0);
    chk("rst_busy", core.busy, 1);
    chk("rst_ready", core.req_ready, 0);
    chk("rst_a1", A1, 0);
    chk("rst_rdata", core.rsp_rdata, 0);
    chk("rst_err", core.rsp_err, 0);
    last_a1 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("turn_busy", core.busy, 1);
    chk("turn_no_rsp", core.rsp_valid, 0);
    chk("turn_c1_z", dut.u_c1_drv.drive_en, 0);
    @(negedge clk);
    chk_idle(32'h0);
  endtask

  initial begin
    logic [2:0]  rc;
    logic [31:0] rw;
    core.req_valid = 1'b0;
    core.req_cmd   = C1_NOP;
    core.req_addr  = '0;
    core.req_wdata = '0;

    // Reset state, then first release.
    #12;
    chk("rst_ready0", core.req_ready, 0);
    chk("rst_valid0", core.rsp_valid, 0);
    chk("rst_err0", core.rsp_err, 0);
    chk("rst_rdata0", core.rsp_rdata, 0);
    chk("rst_busy0", core.busy, 1);
    chk("rst_a10", A1, 0);
    chk("rst_c1z0", dut.u_c1_drv.drive_en, 0);
    chk("rst_d1z0", dut.u_d1_drv.drive_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_turn_busy", core.busy, 1);
    chk("rel_turn_no_rsp", core.rsp_valid, 0);
    @(negedge clk);
    chk_idle(32'h0);

    // Directed cases.
    run_txn(C1_READ16, 15'h1234, 32'h0, 3, 16'hBEEF, 16'h0, 1'b0);
    run_txn(C1_WRITE32, 15'h0456, 32'hDEADBEEF, 0, 16'h0, 16'h0, 1'b0);
    run_txn(C1_READ32, 15'h0100, 32'h0, 0, 16'h5678, 16'h1234, 1'b0);
    run_txn(C1_READ8, 15'h0022, 32'h0, 1, 16'hABCD, 16'h0, 1'b0);
    run_txn(C1_INVALIDATE_LINE, 15'h7F00, 32'h0, 2, 16'h1111, 16'h0, 1'b1);
    run_txn(C1_INVALIDATE_LINE, 15'h7F00, 32'h0, 0, 16'h2222, 16'h0, 1'b0);
    run_txn(C1_NOP, 15'h0555, 32'h0, 0, 16'h0, 16'h0, 1'b0);
    run_txn(C1_WRITE8, 15'h0033, 32'h0000_00A5, 0, 16'h0, 16'h0, 1'b0);
    run_txn(C1_READ16, 15'h0044, 32'h0, TB_TO - 1, 16'hC0DE, 16'h0, 1'b0);

    rst_in_wait(2);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      rc = 3'($urandom);
      rw = $urandom;
      run_txn(rc, ADDR_W'($urandom), rw, int'($urandom_range(0, 4)),
              16'($urandom), 16'($urandom), 1'b0);
    end

`ifdef CPU_TIMEOUT_EN
    run_txn(C1_READ16, 15'h0abc, 32'h0, -1, 16'h0, 16'h0, 1'b0);
    run_txn(C1_READ16, 15'h0abd, 32'h0, 0, 16'h7777, 16'h0, 1'b0);
`else
    rst_in_wait(100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Parametrised CPU-side master for the C1/D1/A1 cache bus.
- Accepts one memory request at a time from a core-side valid/ready port and drives the C1 command, A1 address and D1 data phases.
- Releases the bus, waits for the cache's RESPONSE, captures read data, and returns a one-cycle completion.
- Replaces the free-running command counter with a real request/response protocol engine.

Parameters:
- ADDR_W, 15: A1 / req_addr width.
- DATA_W, 16: D1 width; the widest access (READ32/WRITE32) is 2*DATA_W, sent as two bus words.
- TIMEOUT_CYC, 255: WAIT cycles before abort; used only with CPU_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  master can accept a request.
- req_cmd  in  3  C1 command code: NOP=0, READ8=1, READ16=2, READ32=3, INVALIDATE_LINE=4, WRITE8=5, WRITE16=6, WRITE32=7.
- req_addr  in  ADDR_W  byte/line address.
- req_wdata  in  2*DATA_W  write data, low word first.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  2*DATA_W  read data, zero-extended.
- rsp_err  out  1  completion aborted by timeout.
- busy  out  1  transaction in flight (state != IDLE).
- D1  inout  DATA_W  data bus.
- C1  inout  3  command/response bus; RESPONSE=7 is driven by the cache only.
- A1  out  ADDR_W  address bus.

Behaviour:
- States: IDLE, CMD1, CMD2, WAIT, RESP2, TURN. Reset state is TURN.
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=1, A1=0, C1=Z, D1=Z.
- Reset asserted mid-transaction: immediately release C1/D1 (Z), abort, no rsp_valid.
- Handshake: accept when req_valid && req_ready. req_ready=1 only in IDLE. Request fields are latched on accept; inputs are don't-care afterwards.
- IDLE: drive C1=NOP(0), D1=Z, A1 holds its last value.
- Accepted NOP request: go to TURN with no bus activity; rsp_valid pulses in TURN with rdata=0.
- CMD1 (1 cycle): drive C1=cmd and A1=addr. D1 = wdata[DATA_W-1:0] for WRITE8/16/32, Z otherwise.
  - WRITE32 -> CMD2; all others -> WAIT.
- CMD2 (1 cycle): C1=cmd, D1=wdata[2*DATA_W-1:DATA_W], then -> WAIT.
- WAIT: C1=Z, D1=Z. A1 keeps being driven. On each posedge, sample C1:
  - C1==7 and cmd is a read: capture D1 into rdata low word. READ8 keeps only D1[7:0].
  - READ32 -> RESP2; all others -> TURN.
- RESP2 (1 cycle): capture D1 into rdata high word, -> TURN.
- TURN (1 cycle): C1=Z, D1=Z (bus turnaround). rsp_valid=1 exactly here for every completed or aborted transaction, with rsp_rdata/rsp_err valid. Then -> IDLE.
- Minimum latency, accept edge to rsp_valid:
  - READ16 with immediate response: 3 cycles (CMD1, WAIT, TURN).
  - WRITE32: 4 cycles.
- rsp_rdata holds its value until the next completion. Write and invalidate completions return rdata=0.
- X/Z on C1 during WAIT is treated as not-response.
- The master never drives C1/D1 in WAIT, RESP2 or TURN.

Optional Feature:
- Macro: CPU_TIMEOUT_EN.
- With it: a WAIT-cycle counter of width $clog2(TIMEOUT_CYC+1) clears on entering WAIT. On reaching TIMEOUT_CYC without a response -> TURN with rsp_err=1 and rdata=0. A response on the same edge as the counter hitting TIMEOUT_CYC wins; no error is reported.
- Without it: WAIT lasts indefinitely, rsp_err is tied 0, and no counter exists.

Decomposition:
- Package cpu_bus_pkg holds:
  - C1 command localparams, including C1_RESPONSE=7.
  - The state enum.
  - A helper function is_write(cmd).
- One sub-module, cpu_bus_drv: tristate drivers for C1/D1, inputs drive_en/value.

Test Plan:
- READ16 addr 0x1234; cache drives C1=7, D1=0xBEEF after 3 WAIT cycles -> A1=0x1234 during CMD1; rsp_rdata=0x0000BEEF; single-cycle rsp_valid; rsp_err=0.
- WRITE32 wdata 0xDEADBEEF -> C1=7 for 2 cycles with D1=0xBEEF then 0xDEAD, then C1/D1=Z; response -> rsp_valid, rdata=0.
- READ32; cache drives D1=0x5678 then 0x1234 over RESPONSE+1 cycle -> rsp_rdata=0x12345678; TURN has Z bus; next cycle C1=0.
- READ8 with D1=0xABCD at response -> rsp_rdata=0x000000CD. Back-to-back INVALIDATE_LINE request held valid -> accepted only in IDLE, rsp_valid again with rdata=0.
- rst_n low during WAIT of a READ16 -> C1/D1 Z in the same cycle; no rsp_valid. After release: one TURN cycle, then C1=0 and req_ready=1.
- CPU_TIMEOUT_EN, TIMEOUT_CYC=8, no response -> rsp_valid with rsp_err=1 after 8 WAIT cycles. Built without the macro, the same stimulus keeps busy=1 for 100 cycles.
